// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter
//
// Round-robin write arbiter that lets NUM_REQ producers share one FIFO write port.
// A producer is granted for a burst of up to MAX_BURST words. The burst ends early when the
// producer drops its valid. Every burst is followed by one IDLE cycle, which re-runs the
// round-robin scan.
//
// The FIFO write port is driven from a register stage, so each write reaches the FIFO one cycle
// after it is accepted. The occupancy count (level) is updated when a write is accepted, not when
// it lands. This means the "level < ADDR_AVALABLE" check already includes the write in flight and
// can never overfill the FIFO.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    per-requester data valid
//   req_data     packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester accept (combinational, at most one bit high, only in BURST)
//   fifo_w_en    FIFO write enable (registered)
//   fifo_w_data  FIFO write data (registered, holds its value between writes)
//   fifo_full    FIFO full flag, used as a safety stall
//   fifo_r_en    consumer read enable, monitored for level tracking
//   fifo_empty   FIFO empty flag; a read while empty is ignored by the FIFO
//   level        committed occupancy, including the write in flight
//   almost_full  registered, equals (level >= ALMOST_FULL_TH)
//   grant_id     current or most recently granted requester
//   busy         high while a burst is in progress
module fifo_wr_rr_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ADDR_AVALABLE  = 13,
  parameter int unsigned ALMOST_FULL_TH = 11,
  parameter int unsigned MAX_BURST      = 4,
  localparam int unsigned GRANT_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_full,
  input  logic                          fifo_r_en,
  input  logic                          fifo_empty,
  output logic [ADDR_WIDTH-1:0]         level,
  output logic                          almost_full,
  output logic [GRANT_WIDTH-1:0]        grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam int unsigned CntWidth = 4;

  localparam logic [ADDR_WIDTH-1:0]  LevelOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  LevelMax = ADDR_WIDTH'(ADDR_AVALABLE);
  localparam logic [ADDR_WIDTH-1:0]  LevelAf  = ADDR_WIDTH'(ALMOST_FULL_TH);
  localparam logic [CntWidth-1:0]    CntOne   = CntWidth'(1);
  localparam logic [CntWidth-1:0]    CntLast  = CntWidth'(MAX_BURST - 1);
  // The pointer starts on the highest index so the first scan begins at requester 0.
  localparam logic [GRANT_WIDTH-1:0] LastInit = GRANT_WIDTH'(NUM_REQ - 1);

  state_e                 state_q, state_d;
  logic [GRANT_WIDTH-1:0] grant_q, grant_d;
  logic [GRANT_WIDTH-1:0] last_q, last_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  level_q, level_d;
  logic                   almost_full_q;
  logic                   w_en_q;
  logic [DATA_WIDTH-1:0]  w_data_q;

  logic                   can_accept;
  logic                   accept;
  logic                   dec;

  // Unpack the requester words so the selected word can be indexed by grant.
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan: first valid requester at last+1, last+2, ... with wrap-around.
  logic [GRANT_WIDTH-1:0] scan_cand;
  logic [GRANT_WIDTH-1:0] scan_idx;
  logic                   scan_found;

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_cand = GRANT_WIDTH'((32'(last_q) + k) % NUM_REQ);
      if (!scan_found && req_valid[scan_cand]) begin
        scan_found = 1'b1;
        scan_idx   = scan_cand;
      end
    end
  end

  // Only the committed level is used here. A read in the same cycle does not make room
  // early, because the read may still be rejected by the FIFO.
  assign can_accept = (level_q < LevelMax) & ~fifo_full;

  // A read counts only when the FIFO actually takes it. The level guard keeps the
  // counter from wrapping if the flags ever disagree with it.
  assign dec = fifo_r_en & ~fifo_empty & (level_q != '0);

  // FSM next state, grant bookkeeping and the ready/accept decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (scan_found) begin
          grant_d = scan_idx;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end

      StBurst: begin
        req_ready[grant_q] = can_accept;
        accept             = req_valid[grant_q] & can_accept;
        if (accept) begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end else if (!req_valid[grant_q]) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
        // A stall (valid high, not ready) holds the burst and its count.
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Occupancy: +1 on accept, -1 on an effective read, unchanged when both happen.
  always_comb begin
    level_d = level_q;
    unique case ({accept, dec})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_q        <= LastInit;
      cnt_q         <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
      w_en_q        <= 1'b0;
      w_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      // Computed from the next level so that it lines up with the level output.
      almost_full_q <= (level_d >= LevelAf);
      w_en_q        <= accept;
      if (accept) begin
        w_data_q <= words[grant_q];
      end
    end
  end

  assign fifo_w_en   = w_en_q;
  assign fifo_w_data = w_data_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Bench for fifo_wr_rr_arbiter: directed scenarios plus randomized traffic. A cycle model in
// plain integers predicts every output, and a simple FIFO occupancy counter supplies the
// full and empty flags.
module tb_fifo_wr_rr_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned NR    = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned AVAIL = 13;
  localparam int unsigned AF_TH = 11;
  localparam int unsigned MB    = 4;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data  = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_w_data;
  logic              fifo_full  = 1'b0;
  logic              fifo_r_en  = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [AW-1:0]     level;
  logic              almost_full;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_rr_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .ADDR_WIDTH    (AW),
    .ADDR_AVALABLE (AVAIL),
    .ALMOST_FULL_TH(AF_TH),
    .MAX_BURST     (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_w_en  (fifo_w_en),
    .fifo_w_data(fifo_w_data),
    .fifo_full  (fifo_full),
    .fifo_r_en  (fifo_r_en),
    .fifo_empty (fifo_empty),
    .level      (level),
    .almost_full(almost_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            m_level;
  int            m_grant;
  int            m_last;
  int            m_cnt;
  bit            m_busy;
  bit            m_wen;
  logic [DW-1:0] m_wdata;

  // Environment: FIFO occupancy and stimulus sources
  int            env_cnt;
  bit            env_wen;
  bit            force_full;
  bit            rand_mode;
  bit            rd_cmd;
  int            rd_pct;
  int            src_left [NR];
  logic [DW-1:0] src_next [NR];
  logic [NR-1:0] acc_vec;
  int            acc_log [$];
  logic [DW-1:0] wr_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_grant = 0;
    m_last  = NR - 1;
    m_cnt   = 0;
    m_busy  = 0;
    m_wen   = 0;
    m_wdata = '0;
    env_cnt = 0;
    env_wen = 0;
    for (int i = 0; i < NR; i++) src_left[i] = 0;
  endtask

  task automatic env_flags();
    fifo_empty = (env_cnt == 0);
    fifo_full  = (env_cnt >= AVAIL) || force_full;
  endtask

  // Cycle update of the reference model.
  task automatic model_step();
    bit acc;
    bit rd;
    acc = m_busy && req_valid[m_grant] && (m_level < AVAIL) && !fifo_full;
    rd  = fifo_r_en && !fifo_empty && (m_level > 0);
    m_wen = acc;
    if (acc) m_wdata = req_data[m_grant*DW +: DW];
    m_level = m_level + int'(acc) - int'(rd);
    if (!m_busy) begin
      if (req_valid != '0) begin
        for (int k = 1; k <= NR; k++) begin
          if (req_valid[(m_last + k) % NR]) begin
            m_grant = (m_last + k) % NR;
            break;
          end
        end
        m_cnt  = 0;
        m_busy = 1;
      end
    end else if (acc) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0;
        m_last = m_grant;
      end
    end else if (!req_valid[m_grant]) begin
      m_busy = 0;
      m_last = m_grant;
    end
  endtask

  task automatic compare();
    logic [NR-1:0] er;
    er = '0;
    if (m_busy && (m_level < AVAIL) && !fifo_full) er[m_grant] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("fifo_w_en", 32'(fifo_w_en), 32'(m_wen));
    chk("fifo_w_data", 32'(fifo_w_data), 32'(m_wdata));
    chk("level", 32'(level), m_level);
    chk("almost_full", 32'(almost_full), 32'(m_level >= AF_TH));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), m_grant);
    if (!force_full) chk("w_en_while_full", 32'(fifo_w_en & fifo_full), 32'(0));
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rand_mode) begin
        req_valid[i]         = ($urandom_range(0, 3) != 0);
        req_data[i*DW +: DW] = DW'($urandom);
      end else begin
        req_valid[i]         = (src_left[i] > 0);
        req_data[i*DW +: DW] = src_next[i];
      end
    end
    if (rand_mode) begin
      fifo_r_en  = ($urandom_range(0, 99) < rd_pct);
      force_full = ($urandom_range(0, 15) == 0);
    end else begin
      fifo_r_en  = rd_cmd;
      force_full = 1'b0;
    end
    env_flags();
  endtask

  // One clock: drive, check at negedge, advance model and environment at posedge.
  task automatic tick();
    drive();
    @(negedge clk);
    compare();
    acc_vec = req_ready & req_valid;
    env_wen = fifo_w_en;
    for (int i = 0; i < NR; i++) if (acc_vec[i]) acc_log.push_back(i);
    if (fifo_w_en) wr_log.push_back(fifo_w_data);
    @(posedge clk);
    model_step();
    if (fifo_r_en && !fifo_empty) env_cnt--;
    if (env_wen) env_cnt++;
    for (int i = 0; i < NR; i++) begin
      if (acc_vec[i]) begin
        src_left[i]--;
        src_next[i]++;
      end
    end
    #1;
    env_flags();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_w_en", 32'(fifo_w_en), 32'(0));
    chk("rst_w_data", 32'(fifo_w_data), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_almost_full", 32'(almost_full), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    model_reset();
    rd_cmd    = 1'b0;
    rand_mode = 1'b0;
    drive();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int exp3 [13] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0, 2};
    rd_pct = 33;
    model_reset();
    #2;
    apply_reset();

    // Single producer, six words, no reads
    src_left[0] = 6;
    src_next[0] = 8'hA0;
    wr_log.delete();
    repeat (14) tick();
    chk("t2_writes", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) chk("t2_word", 32'(wr_log[i]), 32'hA0 + i);
    chk("t2_level", 32'(level), 32'd6);

    // Reset mid-run, then a lone request from requester 2
    apply_reset();
    src_left[2] = 1;
    src_next[2] = 8'h5A;
    tick();
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    chk("t1_level", 32'(level), 32'd1);

    // Requesters 0 and 2 always valid, no reads, until full
    apply_reset();
    src_left[0] = 100;
    src_next[0] = 8'h00;
    src_left[2] = 100;
    src_next[2] = 8'h20;
    acc_log.delete();
    repeat (30) tick();
    chk("t3_accepts", acc_log.size(), 13);
    for (int i = 0; i < 13 && i < acc_log.size(); i++) chk("t3_grant_seq", acc_log[i], exp3[i]);
    chk("t3_level", 32'(level), 32'd13);
    chk("t3_almost_full", 32'(almost_full), 32'd1);
    chk("t3_req_ready", 32'(req_ready), 32'd0);

    // One read at full frees exactly one slot
    rd_cmd = 1'b1;
    tick();
    rd_cmd = 1'b0;
    chk("t4_level_after_read", 32'(level), 32'd12);
    tick();
    chk("t4_level_refill", 32'(level), 32'd13);
    repeat (5) tick();
    chk("t4_accepts", acc_log.size(), 14);
    if (acc_log.size() == 14) chk("t4_last_grant", acc_log[13], 2);

    // Accept and read together at level 5
    apply_reset();
    src_left[0] = 5;
    src_next[0] = 8'h10;
    repeat (10) tick();
    chk("t5_level_pre", 32'(level), 32'd5);
    src_left[0] = 1;
    tick();
    rd_cmd = 1'b1;
    tick();
    rd_cmd = 1'b0;
    chk("t5_level_both", 32'(level), 32'd5);
    repeat (3) tick();

    // Reads while empty at level 0
    apply_reset();
    rd_cmd = 1'b1;
    repeat (3) tick();
    rd_cmd = 1'b0;
    chk("t5_level_empty_read", 32'(level), 32'd0);

    // Reset in the middle of a burst
    apply_reset();
    src_left[0] = 1;
    src_next[0] = 8'h40;
    repeat (3) tick();
    src_left[1] = 10;
    src_next[1] = 8'h60;
    repeat (3) tick();
    chk("t6_grant_pre", 32'(grant_id), 32'd1);
    chk("t6_w_en_pre", 32'(fifo_w_en), 32'd1);
    apply_reset();
    src_left[0] = 2;
    src_next[0] = 8'h70;
    src_left[1] = 2;
    src_next[1] = 8'h80;
    tick();
    chk("t6_grant_post", 32'(grant_id), 32'd0);
    repeat (10) tick();

    // Randomized traffic with occasional resets and two read rates
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 0) apply_reset();
      rd_pct    = (n < 1500) ? 33 : 70;
      rand_mode = 1'b1;
      tick();
    end
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
